// File: rtl/bus_pkg.sv
// Shared opcodes, swap timing and issuer state encoding for the bus command front end.
package bus_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SWAP    = 3'd1;
    localparam logic [2:0] OP_MOVE    = 3'd2;
    localparam logic [2:0] OP_LOAD_R1 = 3'd3;
    localparam logic [2:0] OP_LOAD_R2 = 3'd4;
    localparam logic [2:0] OP_LOAD_R3 = 3'd5;

    // Cycles of forced func = 0 after a swap is issued.
    localparam int SWAP_GAP = 2;

    typedef enum logic {
        ST_READY    = 1'b0,
        ST_SWAP_GAP = 1'b1
    } issue_state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LOAD_R1) || (op == OP_LOAD_R2) || (op == OP_LOAD_R3);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_LOAD_R3;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full/empty
// fall out of a plain compare. No pass-through: a full FIFO refuses a push
// even if a pop happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_cmd_issuer.sv
// Command front end for the tri-state register-bus controller: queues ops,
// issues one per slot on func, enforces swap spacing and drives load data
// onto the external bus in the controller's Extern cycle.
module bus_cmd_issuer
    import bus_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd_op,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      cmd_ready,
    output logic [2:0]                func,
    output logic [DATA_W-1:0]         ext_data,
    output logic                      issue,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int EW = 3 + DATA_W;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              accept;
    logic [EW-1:0]     wr_entry;
    logic [EW-1:0]     head;
    logic [2:0]        head_op;
    logic [DATA_W-1:0] head_data;

    issue_state_t      state, state_n;
    logic [1:0]        gap_cnt, gap_n;
    logic              after_swap, after_n;
    logic [2:0]        func_n;
    logic              issue_n;
    logic [DATA_W-1:0] issue_data, data_n;

    assign cmd_ready = !full;
    assign accept    = cmd_valid && cmd_ready;
    // Illegal ops are consumed from the port but never stored.
    assign push      = accept && is_legal(cmd_op);
    assign wr_entry  = {cmd_op, is_load(cmd_op) ? cmd_data : {DATA_W{1'b0}}};
    assign head_op   = head[EW-1 -: 3];
    assign head_data = head[DATA_W-1:0];
    assign busy      = !empty || (state == ST_SWAP_GAP);

    cmd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (Clock),
        .rst_n (Resetn),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Issue decision: pop/issue in READY, hold func at 0 through the swap gap,
    // and hold back a swap in the first READY cycle after a swap.
    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        after_n = 1'b0;
        pop     = 1'b0;
        func_n  = OP_NOP;
        issue_n = 1'b0;
        data_n  = issue_data;
        case (state)
            ST_READY: begin
                if (!empty && !(after_swap && head_op == OP_SWAP)) begin
                    pop     = 1'b1;
                    func_n  = head_op;
                    issue_n = 1'b1;
                    data_n  = head_data;
                    if (head_op == OP_SWAP) begin
                        state_n = ST_SWAP_GAP;
                        gap_n   = 2'(SWAP_GAP);
                    end
                end
            end
            ST_SWAP_GAP: begin
                gap_n = gap_cnt - 2'd1;
                if (gap_cnt == 2'd1) begin
                    state_n = ST_READY;
                    after_n = 1'b1;
                end
            end
            default: state_n = ST_READY;
        endcase
    end

    // Issuer state, registered outputs and the Extern data register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_READY;
            gap_cnt    <= '0;
            after_swap <= 1'b0;
            func       <= OP_NOP;
            issue      <= 1'b0;
            issue_data <= '0;
            err        <= 1'b0;
            ext_data   <= '0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            after_swap <= after_n;
            func       <= func_n;
            issue      <= issue_n;
            issue_data <= data_n;
            err        <= accept && !is_legal(cmd_op);
            // The controller samples the bus the cycle after a load issues.
            if (issue && is_load(func)) ext_data <= issue_data;
        end
    end

endmodule

// File: tb/tb_bus_cmd_issuer.sv
// Self-checking bench for bus_cmd_issuer: directed scenarios from the
// command timing rules plus a randomized run against a slot-timing model.
module tb_bus_cmd_issuer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [2:0]        cmd_op = 3'd0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cmd_ready;
    logic [2:0]        func;
    logic [DATA_W-1:0] ext_data;
    logic              issue;
    logic              err;
    logic              busy;
    logic [2:0]        level;

    int checks = 0;
    int errors = 0;

    bus_cmd_issuer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .func      (func),
        .ext_data  (ext_data),
        .issue     (issue),
        .err       (err),
        .busy      (busy),
        .level     (level)
    );

    always #5 Clock = ~Clock;

    // One clock; inputs change and outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drv(input logic v, input logic [2:0] op, input logic [7:0] d);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cyc();
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        cmd_valid = 1'b0;
        cyc();
        Resetn = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        cyc();
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL reset_func got %0d exp 0", func); end
        checks++; if (ext_data !== 8'h00) begin errors++; $display("FAIL reset_ext got %h exp 00", ext_data); end
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %b exp 0", issue); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
        Resetn = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        drv(1'b1, 3'd3, 8'hA5);  // edge k
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL load_level_k got %0d exp 1", level); end
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL load_func_k got %0d exp 0", func); end
        drv(1'b0, 3'd0, 8'h00);  // k+1
        checks++; if (func !== 3'd3) begin errors++; $display("FAIL load_func_k1 got %0d exp 3", func); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL load_issue_k1 got %b exp 1", issue); end
        checks++; if (ext_data !== 8'h00) begin errors++; $display("FAIL load_ext_k1 got %h exp 00", ext_data); end
        drv(1'b0, 3'd0, 8'h00);  // k+2
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL load_func_k2 got %0d exp 0", func); end
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL load_issue_k2 got %b exp 0", issue); end
        checks++; if (ext_data !== 8'hA5) begin errors++; $display("FAIL load_ext_k2 got %h exp a5", ext_data); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [7:0] dat [3];
        logic [2:0] ef  [5];
        logic [7:0] ee  [5];
        ops = '{3'd2, 3'd4, 3'd5};
        dat = '{8'hEE, 8'h3C, 8'h11};
        ef  = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd0};
        ee  = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h11};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drv(1'b1, ops[i], dat[i]);
            else       drv(1'b0, 3'd0, 8'h00);
            checks++; if (func !== ef[i]) begin errors++; $display("FAIL b2b_func[%0d] got %0d exp %0d", i, func, ef[i]); end
            checks++; if (ext_data !== ee[i]) begin errors++; $display("FAIL b2b_ext[%0d] got %h exp %h", i, ext_data, ee[i]); end
        end
    endtask

    task automatic test_swap();
        logic [2:0] ops [3];
        logic [2:0] ef  [10];
        logic       ei  [10];
        ops = '{3'd1, 3'd1, 3'd2};
        ef  = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0};
        ei  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i < 3) drv(1'b1, ops[i], 8'h00);
            else       drv(1'b0, 3'd0, 8'h00);
            checks++; if (func !== ef[i]) begin errors++; $display("FAIL swap_func[%0d] got %0d exp %0d", i, func, ef[i]); end
            checks++; if (issue !== ei[i]) begin errors++; $display("FAIL swap_issue[%0d] got %b exp %b", i, issue, ei[i]); end
        end
    endtask

    task automatic test_full();
        logic       vv  [14];
        logic [2:0] ops [14];
        logic [7:0] dat [14];
        logic [2:0] ef  [14];
        logic [2:0] el  [14];
        vv  = '{1,1,1,1,1,1,1,0,0,0,0,0,0,0};
        ops = '{3'd1,3'd1,3'd2,3'd2,3'd3,3'd4,3'd4,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0};
        dat = '{8'h0,8'h0,8'h0,8'h0,8'h55,8'h77,8'h77,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0,8'h0};
        ef  = '{3'd0,3'd1,3'd0,3'd0,3'd0,3'd1,3'd0,3'd0,3'd2,3'd2,3'd3,3'd4,3'd0,3'd0};
        el  = '{3'd1,3'd1,3'd2,3'd3,3'd4,3'd3,3'd4,3'd4,3'd3,3'd2,3'd1,3'd0,3'd0,3'd0};
        for (int i = 0; i < 14; i++) begin
            drv(vv[i], ops[i], dat[i]);
            checks++; if (func !== ef[i]) begin errors++; $display("FAIL full_func[%0d] got %0d exp %0d", i, func, ef[i]); end
            checks++; if (level !== el[i]) begin errors++; $display("FAIL full_level[%0d] got %0d exp %0d", i, level, el[i]); end
            checks++; if (cmd_ready !== (el[i] != 3'd4)) begin errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, cmd_ready, el[i] != 3'd4); end
            if (i == 11) begin
                checks++; if (ext_data !== 8'h55) begin errors++; $display("FAIL full_ext_r1 got %h exp 55", ext_data); end
            end
            if (i == 12) begin
                checks++; if (ext_data !== 8'h77) begin errors++; $display("FAIL full_ext_r2 got %h exp 77", ext_data); end
            end
        end
    endtask

    task automatic test_illegal();
        drv(1'b1, 3'd6, 8'h12);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill6_err got %b exp 1", err); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ill6_level got %0d exp 0", level); end
        drv(1'b1, 3'd7, 8'h34);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill7_err got %b exp 1", err); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ill7_level got %0d exp 0", level); end
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL ill7_func got %0d exp 0", func); end
        drv(1'b0, 3'd0, 8'h00);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_clear got %b exp 0", err); end
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL ill_func got %0d exp 0", func); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_swap();
        logic [2:0] ops [5];
        ops = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
        for (int i = 0; i < 5; i++) drv(1'b1, ops[i], 8'h00);
        drv(1'b0, 3'd0, 8'h00);   // second swap issues here
        checks++; if (func !== 3'd1) begin errors++; $display("FAIL rms_swap_func got %0d exp 1", func); end
        drv(1'b0, 3'd0, 8'h00);   // one cycle after the swap issue
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL rms_level_pre got %0d exp 3", level); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rms_busy_pre got %b exp 1", busy); end
        #2 Resetn = 1'b0;
        #1;
        checks++; if (func !== 3'd0) begin errors++; $display("FAIL rms_func got %0d exp 0", func); end
        checks++; if (ext_data !== 8'h00) begin errors++; $display("FAIL rms_ext got %h exp 00", ext_data); end
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rms_issue got %b exp 0", issue); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rms_busy got %b exp 0", busy); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rms_level got %0d exp 0", level); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rms_ready got %b exp 1", cmd_ready); end
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (func !== 3'd0) begin errors++; $display("FAIL rms_post_func[%0d] got %0d exp 0", i, func); end
            checks++; if (level !== 3'd0) begin errors++; $display("FAIL rms_post_level[%0d] got %0d exp 0", i, level); end
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
    } ent_t;

    // Model: a queue of pending commands plus the cycle index of the last
    // swap; a non-swap may issue 3 cycles after it, a swap 4 cycles after it.
    task automatic test_random();
        ent_t       q[$];
        ent_t       h;
        longint     n, ls, need;
        logic [2:0] e_func, op;
        logic       e_issue, e_err, v, acc, e_busy;
        logic [7:0] e_ext, e_data, d;
        do_reset();
        n = 0; ls = -100;
        e_func = 3'd0; e_issue = 1'b0; e_err = 1'b0; e_ext = 8'h00; e_data = 8'h00;
        for (int c = 0; c < 400; c++) begin
            e_busy = (q.size() != 0) || (n == ls) || (n == ls + 1);
            checks++; if (func !== e_func) begin errors++; $display("FAIL rnd_func c%0d got %0d exp %0d", c, func, e_func); end
            checks++; if (issue !== e_issue) begin errors++; $display("FAIL rnd_issue c%0d got %b exp %b", c, issue, e_issue); end
            checks++; if (ext_data !== e_ext) begin errors++; $display("FAIL rnd_ext c%0d got %h exp %h", c, ext_data, e_ext); end
            checks++; if (err !== e_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, err, e_err); end
            checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level c%0d got %0d exp %0d", c, level, q.size()); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, e_busy); end
            checks++; if (cmd_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, cmd_ready, q.size() < DEPTH); end

            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3'd1;
            d  = 8'($urandom);

            acc = v && (q.size() < DEPTH);
            if (e_issue && e_func >= 3'd3 && e_func <= 3'd5) e_ext = e_data;
            e_func = 3'd0; e_issue = 1'b0;
            if (q.size() != 0) begin
                h = q[0];
                need = (h.op == 3'd1) ? ls + 4 : ls + 3;
                if (n + 1 >= need) begin
                    void'(q.pop_front());
                    e_func = h.op; e_issue = 1'b1; e_data = h.data;
                    if (h.op == 3'd1) ls = n + 1;
                end
            end
            if (acc && op <= 3'd5) q.push_back('{op, d});
            e_err = acc && (op > 3'd5);
            n = n + 1;
            drv(v, op, d);
        end
        drv(1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_swap();
        test_full();
        test_illegal();
        test_reset_mid_swap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_cmd_issuer.md
# bus_cmd_issuer

Command front end for the tri-state register-bus controller. Accepts bus operations (swap, move, load R1/R2/R3) over a valid/ready port and buffers them in a small FIFO. Drives the controller's 3-bit `func` input one command per issue slot and presents load data on the external bus source exactly when the controller asserts `Extern`. Enforces the swap occupancy rules so the controller never sees `func` change mid-swap or re-enter a swap from its final swap step.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `DATA_W`, 8: width of load data and bus.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `Clock`  in  1  rising-edge clock.
- `Resetn`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_op`  in  3  opcode: 0 NOP, 1 SWAP, 2 MOVE, 3 LOAD_R1, 4 LOAD_R2, 5 LOAD_R3, 6–7 illegal.
- `cmd_data`  in  DATA_W  load value; ignored for non-load ops.
- `cmd_ready`  out  1  high when the FIFO is not full.
- `func`  out  3  registered opcode to the bus controller.
- `ext_data`  out  DATA_W  registered external bus data.
- `issue`  out  1  one-cycle pulse: `func` holds a newly issued op this cycle.
- `err`  out  1  one-cycle pulse: an illegal opcode was accepted and dropped.
- `busy`  out  1  FIFO non-empty or swap gap in progress.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push when `cmd_valid && cmd_ready`. Ops 6–7 are accepted, not stored, and `err` pulses the next cycle.
- `cmd_ready = !full`. A push into a full FIFO is impossible even when a pop occurs in the same cycle (no pass-through).
- Issuer states: READY, SWAP_GAP.
- READY, FIFO non-empty: pop the head, `func <= op`, `issue <= 1`. For a SWAP, go to SWAP_GAP with `gap_cnt <= 2`.
- READY, FIFO empty: `func <= 0`, `issue <= 0`.
- SWAP_GAP: `func <= 0` and no pop. Decrement `gap_cnt`; return to READY when it reaches 0.
- Swap-after-swap: in the first READY cycle after a SWAP, a SWAP at the head is not popped. `func <= 0` for one extra cycle, then the SWAP issues.
- NOP entries pop and issue as `func = 0` with `issue = 1`, consuming one slot.
- `ext_data`: at the edge following the issue of a LOAD_x, load it with that command's `cmd_data`; otherwise hold.
- Stored entry is {op, data}. Data is discarded for non-load ops.

## Timing
- Reset values: `func = 0`, `ext_data = 0`, `issue = 0`, `err = 0`, `busy = 0`, `level = 0`, `cmd_ready = 1`; FIFO empty; state READY.
- Latency, push to issue with an empty FIFO and READY: push at edge k, `func` valid in cycle k+1.
- Non-swap ops issue back-to-back, one per cycle.
- SWAP issued in cycle t: `func = 0` in t+1 and t+2. Next non-swap op may issue in t+3. Next SWAP issues in t+4 (`func = 0` in t+3).
- LOAD issued in cycle t: `ext_data` equals its data in t+1, the controller's Extern cycle, and holds until the next LOAD.
- Simultaneous push and pop: `level` unchanged.
- When the FIFO is not full, the pop and push happen in the same edge.
- Reset asserted mid-swap: immediate return to reset values. Pending FIFO entries are lost. The controller must be reset in the same window.

## Structure
- Shared package `bus_pkg`:
  - opcode localparams `OP_NOP`, `OP_SWAP`, `OP_MOVE`, `OP_LOAD_R1`, `OP_LOAD_R2`, `OP_LOAD_R3`;
  - `SWAP_GAP = 2`;
  - issuer state encoding.
- Sub-module `cmd_fifo`:
  - synchronous FIFO with parameters `DEPTH` and `W`;
  - ports: push, pop, full, empty, level;
  - wrap-around pointers with an extra MSB.
- Top level holds the issuer FSM, gap counter, opcode check and `ext_data` register.

## Test plan
- Reset, then push LOAD_R1/0xA5 at k → `func = 3`, `issue = 1` in k+1; `ext_data = 0xA5` in k+2; `func = 0` in k+2.
- Push MOVE, LOAD_R2/0x3C, LOAD_R3/0x11 back-to-back → `func` = 2, 4, 5 on consecutive cycles. `ext_data` = 0x3C, then 0x11, each one cycle after its issue.
- Push SWAP, SWAP, MOVE → `func` = 1 at t, 0 at t+1 to t+3, 1 at t+4, 0 at t+5 and t+6, 2 at t+7.
- Hold `func` issue blocked by SWAP gaps and push DEPTH+1 commands → `cmd_ready = 0` at `level = 4`. The fifth command is held on the port and accepted after the next pop. No loss or reordering.
- Push op 6, then op 7 → `err` pulses twice, `level` stays 0, `func` stays 0.
- Assert `Resetn = 0` one cycle after a SWAP issue with 3 entries queued → all outputs at reset values asynchronously. After release the FIFO is empty and `func = 0`.
